// File: rtl/reservation_station_pkg.sv
// Shared micro-architectural types for the issue stage: instruction, writeback
// and reservation-station entry formats plus per-class RS depths.
package reservation_station_pkg;

    localparam int TAG_WIDTH  = 8;
    localparam int DATA_WIDTH = 32;
    localparam int OPC_WIDTH  = 8;
    localparam int PIPE_WIDTH = 2;

    localparam int RS_ALU_DEPTH = 8;
    localparam int RS_MDU_DEPTH = 4;
    localparam int RS_LSQ_DEPTH = 8;

    typedef struct packed {
        logic                  rdy;
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] val;
    } operand_t;

    typedef struct packed {
        logic [OPC_WIDTH-1:0] opcode;
        logic [TAG_WIDTH-1:0] rob_tag;
        operand_t             src1;
        operand_t             src2;
    } instruction_t;

    typedef struct packed {
        logic                  valid;
        logic [TAG_WIDTH-1:0]  dest_tag;
        logic [DATA_WIDTH-1:0] result;
    } writeback_packet_t;

    typedef struct packed {
        logic         valid;
        instruction_t inst;
    } rs_entry_t;

    // Distance from the ROB head; modular so it survives tag wrap-around.
    function automatic logic [TAG_WIDTH-1:0] rob_age(input logic [TAG_WIDTH-1:0] rob_tag,
                                                     input logic [TAG_WIDTH-1:0] rob_head);
        return rob_tag - rob_head;
    endfunction

endpackage

// File: rtl/reservation_station_age_select.sv
// Oldest-first selector: grant[i] is one-hot on the i-th oldest ready entry.
module rs_age_select
    import reservation_station_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int NUM_ISSUE = 2,
    parameter int AGE_W     = 8
) (
    input  logic [DEPTH-1:0]                  ready,
    input  logic [DEPTH-1:0][AGE_W-1:0]       ages,
    output logic [NUM_ISSUE-1:0][DEPTH-1:0]   grant
);

    localparam int RANK_W = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0][RANK_W-1:0] rank;

    // Rank = number of ready entries strictly older; tags are unique so ranks are distinct.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            rank[e] = '0;
            for (int j = 0; j < DEPTH; j++) begin
                if (j != e && ready[j] && ages[j] < ages[e]) begin
                    rank[e] = rank[e] + RANK_W'(1);
                end
            end
        end
        grant = '0;
        for (int i = 0; i < NUM_ISSUE; i++) begin
            for (int e = 0; e < DEPTH; e++) begin
                grant[i][e] = ready[e] && (rank[e] == RANK_W'(i));
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Generic reservation station: packed dispatch writes with CDB snoop, operand
// wakeup, and multi-port oldest-first issue by ROB age.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int DEPTH     = RS_ALU_DEPTH,
    parameter int NUM_WR    = PIPE_WIDTH,
    parameter int NUM_ISSUE = 2,
    parameter int NUM_CDB   = PIPE_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    output logic [NUM_WR-1:0]             rs_rdy,
    input  logic [NUM_WR-1:0]             rs_we,
    input  instruction_t                  rs_entries [NUM_WR],
    input  writeback_packet_t             cdb_ports [NUM_CDB],
    input  logic [TAG_WIDTH-1:0]          rob_head,
    input  logic [NUM_ISSUE-1:0]          issue_rdy,
    output logic [NUM_ISSUE-1:0]          issue_valid,
    output instruction_t                  issue_packet [NUM_ISSUE],
    output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    rs_entry_t                         entries   [DEPTH];
    rs_entry_t                         entries_n [DEPTH];
    logic [DEPTH-1:0]                  ready;
    logic [DEPTH-1:0][TAG_WIDTH-1:0]   ages;
    logic [NUM_ISSUE-1:0][DEPTH-1:0]   grant;
    logic [NUM_ISSUE-1:0][DEPTH-1:0]   port_grant;
    logic [DEPTH-1:0]                  issued;
    logic [DEPTH-1:0]                  taken;
    logic                              placed;
    logic [OCC_W-1:0]                  free_cnt;

    function automatic operand_t snoop(input operand_t src);
        operand_t res;
        res = src;
        for (int c = 0; c < NUM_CDB; c++) begin
            if (!src.rdy && cdb_ports[c].valid && cdb_ports[c].dest_tag == src.tag) begin
                res.rdy = 1'b1;
                res.val = cdb_ports[c].result;
            end
        end
        return res;
    endfunction

    always_comb begin
        occupancy = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (entries[e].valid) occupancy = occupancy + OCC_W'(1);
        end
        free_cnt = OCC_W'(DEPTH) - occupancy;
        for (int k = 0; k < NUM_WR; k++) begin
            rs_rdy[k] = free_cnt > OCC_W'(k);
        end
    end

    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            ready[e] = entries[e].valid && entries[e].inst.src1.rdy && entries[e].inst.src2.rdy;
            ages[e]  = rob_age(entries[e].inst.rob_tag, rob_head);
        end
    end

    rs_age_select #(
        .DEPTH     (DEPTH),
        .NUM_ISSUE (NUM_ISSUE),
        .AGE_W     (TAG_WIDTH)
    ) u_age_select (
        .ready (ready),
        .ages  (ages),
        .grant (grant)
    );

    // The n-th accepting port (ascending index) takes the n-th oldest grant.
    always_comb begin
        int ord;
        ord        = 0;
        port_grant = '0;
        issued     = '0;
        for (int k = 0; k < NUM_ISSUE; k++) begin
            if (issue_rdy[k]) begin
                for (int o = 0; o < NUM_ISSUE; o++) begin
                    if (o == ord) port_grant[k] = grant[o];
                end
                ord++;
            end
        end
        for (int k = 0; k < NUM_ISSUE; k++) begin
            issue_valid[k]  = 1'b0;
            issue_packet[k] = '0;
            for (int e = 0; e < DEPTH; e++) begin
                if (port_grant[k][e]) begin
                    issue_valid[k]  = 1'b1;
                    issue_packet[k] = entries[e].inst;
                    issued[e]       = 1'b1;
                end
            end
        end
    end

    // Allocation only looks at registered valid bits, so same-cycle frees are not reused.
    always_comb begin
        taken  = '0;
        placed = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            entries_n[e] = entries[e];
            if (entries[e].valid) begin
                if (issued[e]) begin
                    entries_n[e].valid = 1'b0;
                end else begin
                    entries_n[e].inst.src1 = snoop(entries[e].inst.src1);
                    entries_n[e].inst.src2 = snoop(entries[e].inst.src2);
                end
            end
        end
        for (int k = 0; k < NUM_WR; k++) begin
            placed = 1'b0;
            if (rs_we[k] && rs_rdy[k]) begin
                for (int e = 0; e < DEPTH; e++) begin
                    if (!placed && !entries[e].valid && !taken[e]) begin
                        entries_n[e].valid     = 1'b1;
                        entries_n[e].inst      = rs_entries[k];
                        entries_n[e].inst.src1 = snoop(rs_entries[k].src1);
                        entries_n[e].inst.src2 = snoop(rs_entries[k].src2);
                        taken[e]               = 1'b1;
                        placed                 = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int e = 0; e < DEPTH; e++) entries[e].valid <= 1'b0;
        end else begin
            for (int e = 0; e < DEPTH; e++) entries[e] <= entries_n[e];
        end
    end

    for (genvar k = 0; k < NUM_WR; k++) begin : g_we_check
        a_we_dropped: assert property (@(posedge clk) disable iff (rst) !(rs_we[k] && !rs_rdy[k]));
    end

endmodule
